// File: rtl/acf_inverse_search.sv
// Brute-force inverse autocorrelator: scans candidates 0..2^N-1 in ascending order and
// returns the first whose serially-computed ACF (one bit product per cycle) matches target.
module acf_inverse_search #(
  parameter  int N = 3,
  localparam int W = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [N-1:0]   seq
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [N*W-1:0] tgt_q;
  logic [N-1:0]   cand_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  j_q;
  logic [W-1:0]   acc_q;
  logic           busy_q;
  logic           done_q;
  logic           found_q;
  logic [N-1:0]   seq_q;

  logic [KW:0]    idx;
  logic           prod;
  logic           last_j;
  logic [W-1:0]   acc_d;
  logic [W-1:0]   tgt_lag;

  // j+k never exceeds N-1, so the low KW bits of the sum are a valid bit index
  always_comb begin
    idx    = {1'b0, j_q} + {1'b0, k_q};
    prod   = cand_q[j_q] & cand_q[idx[KW-1:0]];
    last_j = (idx == (KW+1)'(N-1));
    acc_d  = acc_q + {{(W-1){1'b0}}, prod};
    tgt_lag = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) tgt_lag = tgt_q[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cand_q  <= '0;
      k_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      seq_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            tgt_q   <= target;
            cand_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (last_j) state_q <= S_CHECK;
          else        j_q     <= j_q + KW'(1);
        end
        S_CHECK: begin
          // A mismatch on any lag rejects the candidate without evaluating later lags
          if (acc_q != tgt_lag) begin
            state_q <= S_NEXT;
          end else if (k_q == K_LAST) begin
            seq_q   <= cand_q;
            found_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q     <= k_q + KW'(1);
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_NEXT: begin
          if (&cand_q) begin
            seq_q   <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cand_q  <= cand_q + N'(1);
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign seq   = seq_q;

endmodule

// File: tb/tb_acf_inverse_search.sv
// Directed and random searches checked against an arithmetic ACF search model.
module tb_acf_inverse_search;
  localparam int N = 3;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] target;
  logic           busy;
  logic           done;
  logic           found;
  logic [N-1:0]   seq;

  int n_cmp = 0;
  int n_bad = 0;

  acf_inverse_search #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .target(target),
    .busy  (busy),
    .done  (done),
    .found (found),
    .seq   (seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int lag_of(input int s, input int k);
    int sum = 0;
    for (int j = 0; j + k < N; j++) sum += ((s >> j) & 1) & ((s >> (j + k)) & 1);
    return sum;
  endfunction

  function automatic logic [N*W-1:0] acf_vec(input int s);
    logic [N*W-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(lag_of(s, k));
    return v;
  endfunction

  // Exhaustive search with the published cycle cost: lag k costs N-k+1, rejection adds 1
  task automatic model(input logic [N*W-1:0] tg, output int f, output int sq, output int done_cyc);
    int cyc = 0;
    f = 0; sq = 0;
    for (int c = 0; c < (1 << N); c++) begin
      bit ok = 1'b1;
      for (int k = 0; k < N && ok; k++) begin
        cyc += N - k + 1;
        if (lag_of(c, k) != int'(tg[k*W +: W])) ok = 1'b0;
      end
      if (ok) begin f = 1; sq = c; break; end
      cyc += 1;
    end
    done_cyc = cyc + 1;
  endtask

  task automatic run_search(input string name, input logic [N*W-1:0] tg, input bit disturb,
                            input int exp_found, input int exp_seq, input int exp_done);
    int c = 0, done_cyc = 0, ndone = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    target = tg;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (c < 300) begin
      @(negedge clk);
      c++;
      if (disturb && c == 5)  begin start = 1'b1; target = ~tg; end
      if (disturb && c == 6)  start = 1'b0;
      if (disturb && c == 12) target = N*W'($urandom);
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (done_cyc == 0 || c == done_cyc) busy_ok &= (busy === 1'b1);
      else                                busy_ok &= (busy === 1'b0);
      if (done_cyc != 0 && c >= done_cyc + 2) break;
    end
    check({name, " done_cycle"}, done_cyc, exp_done);
    check({name, " done_pulses"}, ndone, 1);
    check({name, " busy_window"}, int'(busy_ok), 1);
    check({name, " found"}, int'(found), exp_found);
    check({name, " seq"}, int'(seq), exp_seq);
  endtask

  initial begin
    int f, sq, dc, s;
    logic [N*W-1:0] tg;

    rst = 1'b1; start = 1'b0; target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset found", int'(found), 0);
    check("reset seq", int'(seq), 0);
    rst = 1'b0;

    run_search("t1_all_zero", 6'b00_00_00, 1'b0, 1, 3'b000, 10);
    run_search("t2_101", 6'b01_00_10, 1'b0, 1, 3'b101, 38);
    model(6'b00_01_10, f, sq, dc);
    run_search("t3_lowest_mirror", 6'b00_01_10, 1'b0, 1, 3'b011, dc);
    model(6'b00_01_00, f, sq, dc);
    run_search("t4_impossible", 6'b00_01_00, 1'b0, 0, 0, dc);
    run_search("t5_disturbed", 6'b01_00_10, 1'b1, 1, 3'b101, 38);

    // Abandon a search midway; registered results must clear one cycle later
    @(negedge clk);
    target = 6'b01_00_10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6 busy", int'(busy), 0);
    check("t6 done", int'(done), 0);
    check("t6 found", int'(found), 0);
    check("t6 seq", int'(seq), 0);
    run_search("t6_after_rst", 6'b00_00_00, 1'b0, 1, 3'b000, 10);

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        s  = int'($urandom_range(0, (1 << N) - 1));
        tg = acf_vec(s);
      end else begin
        tg = N*W'($urandom);
      end
      model(tg, f, sq, dc);
      run_search($sformatf("rand%0d", i), tg, 1'b0, f, sq, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
